hazard_scoreboard: RTL and testbench

Producer-side hazard tracker for the RISC-V pipeline. It records every destination register issued from ID into EX and follows it through EX, MEM and WB in a shadow pipeline. From that record it raises the stall requests that forwarding cannot resolve: load-use, and branch compare in ID against a value not yet available. It sits beside the ID stage and drives the PC/IF_ID write-enables and the ID_EX bubble mux.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 85 ++++++++
 tb/tb_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// master drives the ID instruction fields, slave returns stall/pending status.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16,
    parameter int NREG  = 32
);
    logic             issue_valid_i;
    logic [4:0]       issue_rd_i;
    logic             issue_regwrite_i;
    logic             issue_memread_i;
    logic [4:0]       issue_rs_i;
    logic [4:0]       issue_rt_i;
    logic             issue_use_rs_i;
    logic             issue_use_rt_i;
    logic             issue_branch_i;
    logic             flush_i;
    logic             ext_stall_i;
    logic             stall_o;
    logic             load_use_o;
    logic             branch_stall_o;
    logic [NREG-1:0]  pending_o;
    logic [CNT_W-1:0] stall_count_o;

    modport master (
        output issue_valid_i, issue_rd_i, issue_regwrite_i,
        output issue_memread_i, issue_rs_i, issue_rt_i,
        output issue_use_rs_i, issue_use_rt_i, issue_branch_i,
        output flush_i, ext_stall_i,
        input  stall_o, load_use_o, branch_stall_o,
        input  pending_o, stall_count_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_regwrite_i,
        input  issue_memread_i, issue_rs_i, issue_rt_i,
        input  issue_use_rs_i, issue_use_rt_i, issue_branch_i,
        input  flush_i, ext_stall_i,
        output stall_o, load_use_o, branch_stall_o,
        output pending_o, stall_count_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker: shadows rd of EX/MEM/WB and raises
// load-use and branch-operand stalls that forwarding cannot cover.
module hazard_scoreboard #(
    parameter int CNT_W = 16,
    parameter int NREG  = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    hazard_scoreboard_if.slave sb
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } shadow_t;

    shadow_t          ex_q;
    shadow_t          mem_q;
    shadow_t          wb_q;
    logic [CNT_W-1:0] count_q;

    logic rs_act;
    logic rt_act;
    logic load_use;
    logic branch_stall;
    logic stall;

    function automatic logic writes(input shadow_t s, input logic [4:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != 5'd0);
    endfunction

    // Stall decision from the ID sources against the shadow stages.
    always_comb begin
        rs_act = sb.issue_valid_i && !sb.flush_i && sb.issue_use_rs_i;
        rt_act = sb.issue_valid_i && !sb.flush_i && sb.issue_use_rt_i;
        load_use = (rs_act && ex_q.memread && writes(ex_q, sb.issue_rs_i))
                 | (rt_act && ex_q.memread && writes(ex_q, sb.issue_rt_i));
        branch_stall = sb.issue_branch_i && (
              (rs_act && (writes(ex_q, sb.issue_rs_i)
                       || (mem_q.memread && writes(mem_q, sb.issue_rs_i))))
            | (rt_act && (writes(ex_q, sb.issue_rt_i)
                       || (mem_q.memread && writes(mem_q, sb.issue_rt_i)))));
        stall = load_use | branch_stall;
    end

    // Registers with a write still in flight anywhere in EX/MEM/WB.
    always_comb begin
        sb.pending_o = '0;
        for (int r = 1; r < NREG; r++) begin
            sb.pending_o[r] = writes(ex_q, 5'(r))
                            | writes(mem_q, 5'(r))
                            | writes(wb_q, 5'(r));
        end
    end

    assign sb.stall_o        = stall;
    assign sb.load_use_o     = load_use;
    assign sb.branch_stall_o = branch_stall;
    assign sb.stall_count_o  = count_q;

    // Advance the shadow pipeline and stall counter unless frozen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            count_q <= '0;
        end else if (!sb.ext_stall_i) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (sb.issue_valid_i && !sb.flush_i && !stall) begin
                ex_q <= '{valid:    1'b1,
                          rd:       sb.issue_rd_i,
                          regwrite: sb.issue_regwrite_i,
                          memread:  sb.issue_memread_i};
            end else begin
                ex_q <= '0;
            end
            if (stall && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed vector table, hand sequences for
// freeze/saturation/reset, and random stimulus against an age-based model.
module tb_hazard_scoreboard;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    hazard_scoreboard_if #(.CNT_W(CW), .NREG(32)) bus ();

    hazard_scoreboard #(.CNT_W(CW), .NREG(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sb     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
        bit [4:0] rs;
        bit       urs;
        bit [4:0] rt;
        bit       urt;
        bit       br;
        bit       fl;
        bit       ex;
    } in_t;

    typedef struct {
        in_t         i;
        bit          st;
        bit          lu;
        bit          bs;
        logic [31:0] pd;
        int          cnt;
    } vec_t;

    // In-flight instruction, tracked by how many unfrozen edges it has seen.
    typedef struct {
        bit [4:0] rd;
        bit       rw;
        bit       mr;
        int       age;
    } fl_t;

    fl_t q[$];
    int  m_cnt;
    bit  m_st, m_lu, m_bs;
    logic [31:0] m_pd;

    function automatic in_t mk(bit v, int rd, bit rw, bit mr, int rs,
                               bit urs, int rt, bit urt, bit br,
                               bit fl, bit ex);
        in_t r;
        r.v = v; r.rd = 5'(rd); r.rw = rw; r.mr = mr;
        r.rs = 5'(rs); r.urs = urs; r.rt = 5'(rt); r.urt = urt;
        r.br = br; r.fl = fl; r.ex = ex;
        return r;
    endfunction

    function automatic in_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t V(in_t i, bit st, bit lu, bit bs,
                               logic [31:0] pd, int cnt);
        vec_t r;
        r.i = i; r.st = st; r.lu = lu; r.bs = bs; r.pd = pd; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(in_t i);
        bus.issue_valid_i    = i.v;
        bus.issue_rd_i       = i.rd;
        bus.issue_regwrite_i = i.rw;
        bus.issue_memread_i  = i.mr;
        bus.issue_rs_i       = i.rs;
        bus.issue_use_rs_i   = i.urs;
        bus.issue_rt_i       = i.rt;
        bus.issue_use_rt_i   = i.urt;
        bus.issue_branch_i   = i.br;
        bus.flush_i          = i.fl;
        bus.ext_stall_i      = i.ex;
    endtask

    function automatic bit wr_at(bit [4:0] src, int age, bit need_mr);
        foreach (q[k]) begin
            if (q[k].age == age && q[k].rw && q[k].rd == src &&
                src != 5'd0 && (!need_mr || q[k].mr))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model outputs for the current inputs.
    task automatic model_eval(in_t i);
        bit a_rs, a_rt;
        a_rs = i.v && !i.fl && i.urs;
        a_rt = i.v && !i.fl && i.urt;
        m_lu = (a_rs && wr_at(i.rs, 0, 1)) || (a_rt && wr_at(i.rt, 0, 1));
        m_bs = i.br && ((a_rs && (wr_at(i.rs, 0, 0) || wr_at(i.rs, 1, 1))) ||
                        (a_rt && (wr_at(i.rt, 0, 0) || wr_at(i.rt, 1, 1))));
        m_st = m_lu || m_bs;
        m_pd = '0;
        foreach (q[k]) if (q[k].rw && q[k].rd != 5'd0) m_pd[q[k].rd] = 1'b1;
    endtask

    task automatic model_edge(in_t i);
        fl_t n;
        fl_t keep[$];
        if (i.ex) return;
        foreach (q[k]) begin
            n = q[k];
            n.age++;
            if (n.age <= 2) keep.push_back(n);
        end
        q = keep;
        if (i.v && !i.fl && !m_st) begin
            n.rd = i.rd; n.rw = i.rw; n.mr = i.mr; n.age = 0;
            q.push_back(n);
        end
        if (m_st && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
    endtask

    // One cycle: drive, compare against model, clock, advance model.
    task automatic step(in_t i);
        drive(i);
        #2;
        model_eval(i);
        check("stall", 32'(bus.stall_o), 32'(m_st));
        check("load_use", 32'(bus.load_use_o), 32'(m_lu));
        check("branch_stall", 32'(bus.branch_stall_o), 32'(m_bs));
        check("pending", bus.pending_o, m_pd);
        check("count", 32'(bus.stall_count_o), 32'(m_cnt));
        @(posedge clk);
        #1;
        model_edge(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(idle());
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    in_t  ld5, use5, u5f, u5x;

    initial begin
        rst_n = 1'b0;
        drive(idle());
        model_reset();
        #3;
        check("rst_stall", 32'(bus.stall_o), 0);
        check("rst_pending", bus.pending_o, 0);
        check("rst_count", 32'(bus.stall_count_o), 0);
        do_reset();

        ld5  = mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        use5 = mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 0, 0);
        u5f  = mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 1, 0);
        u5x  = mk(1, 6, 1, 0, 5, 1, 0, 0, 0, 0, 1);

        tbl.push_back(V(ld5, 0, 0, 0, 32'h0, 0));
        tbl.push_back(V(use5, 1, 1, 0, 32'h20, 0));
        tbl.push_back(V(use5, 0, 0, 0, 32'h20, 1));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h60, 1));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h40, 1));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h40, 1));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 1));
        tbl.push_back(V(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1));
        tbl.push_back(V(mk(1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0), 1, 0, 1, 32'h80, 1));
        tbl.push_back(V(mk(1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0), 0, 0, 0, 32'h80, 2));
        tbl.push_back(V(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 32'h80, 2));
        tbl.push_back(V(mk(1, 0, 0, 0, 1, 1, 7, 1, 1, 0, 0), 1, 1, 1, 32'h80, 2));
        tbl.push_back(V(mk(1, 0, 0, 0, 1, 1, 7, 1, 1, 0, 0), 1, 0, 1, 32'h80, 3));
        tbl.push_back(V(mk(1, 0, 0, 0, 1, 1, 7, 1, 1, 0, 0), 0, 0, 0, 32'h80, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 4));
        tbl.push_back(V(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(ld5, 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(u5f, 0, 0, 0, 32'h20, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h20, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h20, 4));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(ld5, 0, 0, 0, 32'h0, 4));
        tbl.push_back(V(u5x, 1, 1, 0, 32'h20, 4));
        tbl.push_back(V(u5x, 1, 1, 0, 32'h20, 4));
        tbl.push_back(V(u5x, 1, 1, 0, 32'h20, 4));
        tbl.push_back(V(use5, 1, 1, 0, 32'h20, 4));
        tbl.push_back(V(use5, 0, 0, 0, 32'h20, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h60, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h40, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h40, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 5));
        tbl.push_back(V(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h8, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h8, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h8, 5));
        tbl.push_back(V(idle(), 0, 0, 0, 32'h0, 5));

        foreach (tbl[n]) begin
            drive(tbl[n].i);
            #2;
            check($sformatf("v%0d_stall", n), 32'(bus.stall_o), 32'(tbl[n].st));
            check($sformatf("v%0d_lu", n), 32'(bus.load_use_o), 32'(tbl[n].lu));
            check($sformatf("v%0d_bs", n), 32'(bus.branch_stall_o), 32'(tbl[n].bs));
            check($sformatf("v%0d_pend", n), bus.pending_o, tbl[n].pd);
            check($sformatf("v%0d_cnt", n), 32'(bus.stall_count_o), 32'(tbl[n].cnt));
            @(posedge clk);
            #1;
        end

        // Saturation: a self-dependent load every cycle stalls every other cycle.
        do_reset();
        for (int k = 0; k < 40; k++) step(mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0));
        check("sat_count", 32'(bus.stall_count_o), CMAX);

        // Reset asserted mid-stall clears everything immediately.
        step(mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        drive(use5);
        #2;
        check("pre_rst_stall", 32'(bus.stall_o), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(bus.stall_o), 0);
        check("mid_rst_lu", 32'(bus.load_use_o), 0);
        check("mid_rst_pend", bus.pending_o, 0);
        check("mid_rst_cnt", 32'(bus.stall_count_o), 0);
        do_reset();

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            in_t r;
            r.v   = ($urandom_range(0, 9) < 8);
            r.rd  = 5'($urandom_range(0, 7));
            r.rw  = ($urandom_range(0, 3) != 0);
            r.mr  = ($urandom_range(0, 2) == 0);
            r.rs  = 5'($urandom_range(0, 7));
            r.rt  = 5'($urandom_range(0, 7));
            r.urs = ($urandom_range(0, 3) != 0);
            r.urt = ($urandom_range(0, 1) != 0);
            r.br  = ($urandom_range(0, 3) == 0);
            r.fl  = ($urandom_range(0, 9) == 0);
            r.ex  = ($urandom_range(0, 9) == 0);
            step(r);
            if (k == 200) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
